// File: rtl/pkt_stage_fifo.sv
// pkt_stage_fifo: elastic DEPTH-entry packet buffer between pipeline stages with flush and drop counting.
// Optional same-cycle pass-through when empty: define PKT_STAGE_FIFO_BYPASS_EN.
module pkt_stage_fifo #(
    parameter int WIDTH        = 256,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_packet,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_packet,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic [7:0]                 flush_drops
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             bypass, push, pop, empty;
    logic [8:0]       drops_sum;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

`ifdef PKT_STAGE_FIFO_BYPASS_EN
    assign bypass = empty & in_valid & out_ready & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign empty       = (count == '0);
    assign in_ready    = (count != CW'(DEPTH));
    assign out_valid   = ~empty | bypass;
    assign out_packet  = bypass ? in_packet : (empty ? '0 : mem[rd_ptr]);
    assign almost_full = (count >= CW'(AFULL_THRESH));
    assign push        = in_valid & in_ready & ~bypass & ~flush;
    assign pop         = ~empty & out_ready & ~flush;
    assign drops_sum   = {1'b0, flush_drops} + 9'(count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            flush_drops <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            flush_drops <= drops_sum[8] ? 8'hff : drops_sum[7:0];
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; gating on rst_n keeps a write from landing while reset is held.
    always_ff @(posedge clk) begin
        if (push && rst_n) mem[wr_ptr] <= in_packet;
    end
endmodule

// File: tb/tb_pkt_stage_fifo.sv
// tb_pkt_stage_fifo: directed scoreboard bench driving a DEPTH=4 and a DEPTH=3 instance with shared stimulus.
module tb_pkt_stage_fifo;
    localparam int W = 256;
`ifdef PKT_STAGE_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_packet = '0;
    logic ir_a, ov_a, af_a, ir_b, ov_b, af_b;
    logic [W-1:0] op_a, op_b;
    logic [2:0] cnt_a;
    logic [1:0] cnt_b;
    logic [7:0] fd_a, fd_b;

    int checks = 0, errors = 0;
    logic [W-1:0] qa[$], qb[$];
    int mc[2], md[2];

    always #5 clk = ~clk;

    pkt_stage_fifo #(.WIDTH(W), .DEPTH(4), .AFULL_THRESH(3)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
        .in_packet(in_packet), .out_valid(ov_a), .out_ready(out_ready), .out_packet(op_a),
        .count(cnt_a), .almost_full(af_a), .flush_drops(fd_a));

    pkt_stage_fifo #(.WIDTH(W), .DEPTH(3), .AFULL_THRESH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
        .in_packet(in_packet), .out_valid(ov_b), .out_ready(out_ready), .out_packet(op_b),
        .count(cnt_b), .almost_full(af_b), .flush_drops(fd_b));

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare one instance against the model, then advance the model across the coming edge.
    task automatic unit(input int k, input int d, input int t, input logic ir, input logic ov,
                        input logic af, input logic [W-1:0] op, input int cnt, input int fd);
        logic [W-1:0] front;
        bit byp, push, pop;
        int sum;
        if (k == 0) front = (qa.size() != 0) ? qa[0] : '0;
        else        front = (qb.size() != 0) ? qb[0] : '0;
        byp = BYP && mc[k] == 0 && in_valid && out_ready && !flush;
        chk($sformatf("u%0d in_ready", k), W'(ir), W'(mc[k] != d));
        chk($sformatf("u%0d out_valid", k), W'(ov), W'(mc[k] != 0 || byp));
        chk($sformatf("u%0d out_packet", k), op, byp ? in_packet : front);
        chk($sformatf("u%0d count", k), W'(cnt), W'(mc[k]));
        chk($sformatf("u%0d almost_full", k), W'(af), W'(mc[k] >= t));
        chk($sformatf("u%0d flush_drops", k), W'(fd), W'(md[k]));
        if (flush) begin
            sum = md[k] + mc[k];
            md[k] = (sum > 255) ? 255 : sum;
            mc[k] = 0;
            if (k == 0) qa.delete(); else qb.delete();
        end else begin
            push = in_valid && mc[k] != d && !byp;
            pop  = mc[k] != 0 && out_ready;
            if (pop)  begin if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front()); end
            if (push) begin if (k == 0) qa.push_back(in_packet); else qb.push_back(in_packet); end
            mc[k] = mc[k] + int'(push) - int'(pop);
        end
    endtask

    task automatic check_both();
        unit(0, 4, 3, ir_a, ov_a, af_a, op_a, int'(cnt_a), int'(fd_a));
        unit(1, 3, 2, ir_b, ov_b, af_b, op_b, int'(cnt_b), int'(fd_b));
    endtask

    task automatic step(input logic iv, input logic [W-1:0] pkt, input logic ordy, input logic fl);
        in_valid = iv; in_packet = pkt; out_ready = ordy; flush = fl;
        #1;
        check_both();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mc = '{0, 0};
        md = '{0, 0};
        repeat (2) @(posedge clk);
        #1;
        check_both();
        rst_n = 1'b1;
        step(0, '0, 0, 0);
        // Fill with consumer stalled; out_packet must hold the oldest entry throughout.
        for (int i = 1; i <= 5; i++) step(1, W'(8'hA0 + i), 0, 0);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
        // Continuous push+pop exercises pointer wrap on both depths.
        for (int i = 1; i <= 10; i++) step(1, W'(i), 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, W'(8'hB0 + i), 0, 0);
        step(1, W'(8'hFF), 1, 1);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        step(1, W'(8'h55), 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        // Repeated full flushes drive flush_drops into saturation.
        for (int n = 0; n < 70; n++) begin
            for (int i = 0; i < 4; i++) step(1, W'(n * 4 + i + 1), 0, 0);
            step(0, '0, 0, 1);
        end
        step(0, '0, 0, 0);
        for (int i = 0; i < 2; i++) step(1, W'(8'hC0 + i), 0, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mc = '{0, 0};
        md = '{0, 0};
        qa.delete();
        qb.delete();
        check_both();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, '0, 1, 0);
        step(1, W'(8'hD1), 1, 0);
        step(0, '0, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pkt_stage_fifo.md
Name: pkt_stage_fifo

Overview:
- Parametrised elastic pipeline-stage buffer for packed pipeline packets (data + decoded instruction + control bundles) moving between CPU stages, e.g. IF->ID decoupling.
- Generalises the single fixed inter-stage packet register to a DEPTH-entry FIFO with valid/ready handshakes, almost-full back-pressure, and a flush for branch mispredict / redirect.
- Sits between a producer stage and a consumer stage; carries opaque WIDTH-bit packets.

Parameters:
- WIDTH, 256, packet width in bits; the packet is opaque to this block.
- DEPTH, 4, number of entries; legal range 2..64; need not be a power of two.
- AFULL_THRESH, 3, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush: discard all stored entries.
- in_valid  in  1  producer offers in_packet.
- in_ready  out  1  buffer can accept this cycle.
- in_packet  in  WIDTH  incoming packet.
- out_valid  out  1  out_packet is valid.
- out_ready  in  1  consumer takes out_packet this cycle.
- out_packet  out  WIDTH  oldest stored packet.
- count  out  $clog2(DEPTH+1)  number of stored entries.
- almost_full  out  1  count >= AFULL_THRESH.
- flush_drops  out  8  saturating count of valid entries discarded by flushes.

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, flush_drops=0. Outputs: out_valid=0, in_ready=1, almost_full=0, out_packet=0. Storage contents are don't-care.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). This is combinational from state only, with no dependence on out_ready.
- out_valid = (count != 0). out_packet = mem[rd_ptr], read combinationally; forced to 0 when empty.
- Latency: a packet pushed in cycle N is visible on out_packet in cycle N+1 at the earliest (without the optional feature).
- Push: mem[wr_ptr] <= in_packet; wr_ptr advances and wraps from DEPTH-1 to 0.
- Pop: rd_ptr advances with the same wrap rule.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full: in_ready=0 and in_valid is ignored. A pop in the same cycle still occurs, and in_ready rises the next cycle.
- Empty: out_valid=0 and out_ready is ignored.
- Flush (synchronous, highest priority):
  - Next state: wr_ptr=rd_ptr=0, count=0.
  - Any push and pop in the same cycle are discarded.
  - flush_drops += count (the pre-flush value), saturating at 255.
- Packet data must hold stable on out_packet while out_valid=1 and out_ready=0.
- Reset asserted mid-operation: state clears immediately; no partial write survives.
- No state machine beyond the pointer/count registers. The design must be synthesizable with no latches.

Optional Feature:
- Macro: PKT_STAGE_FIFO_BYPASS_EN.
- Defined: when count==0, in_valid=1, out_ready=1 and flush=0:
  - The packet passes combinationally: out_valid=1, out_packet=in_packet.
  - No entry is written; pointers and count are unchanged.
  - If out_ready=0, the packet is stored normally.
- Not defined: an empty buffer always shows out_valid=0; minimum latency is 1 cycle.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0, almost_full=0, flush_drops=0.
- Push 0xA1,0xA2,0xA3,0xA4 with out_ready=0 (DEPTH=4) -> count=4, in_ready=0, almost_full=1 from the 3rd push onward; a 5th in_valid (0xA5) is not accepted.
- From full, out_ready=1 for 4 cycles with in_valid=0 -> out_packet sequence 0xA1..0xA4 in order, then out_valid=0.
- Wrap-around with DEPTH=3: continuous push+pop of 0x01..0x0A -> outputs 0x01..0x0A in order, count constant at 1 after the first push.
- Three entries stored, flush=1 together with in_valid=1 (0xFF) and out_ready=1 -> next cycle count=0, out_valid=0, flush_drops=3, 0xFF never appears.
- PKT_STAGE_FIFO_BYPASS_EN defined, empty, in_valid=1 (0x55), out_ready=1 -> out_packet=0x55 the same cycle, count stays 0. Undefined: out_packet=0x55 appears on the next cycle.
